// File: rtl/alu_result_fifo.sv
// Result FIFO behind the 8-bit signed ALU, with a sticky overflow flag and a saturating overflow count.
// Optional: define ALU_RES_SAT_EN to saturate Z on overflow instead of storing the wrapped value.
module alu_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned CW    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_z,
    input  logic                       in_of,
    input  logic [2:0]                 in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_z,
    output logic                       out_of,
    output logic [2:0]                 out_op,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       of_sticky,
    input  logic                       of_clear,
    output logic [CW-1:0]              ovf_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_z  [DEPTH];
    logic          mem_of [DEPTH];
    logic [2:0]    mem_op [DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          of_sticky_q;
    logic [CW-1:0] ovf_cnt_q;

    logic          full, empty, push, pop;
    logic [W-1:0]  store_z;

    always_comb begin
        full  = (count_q == (AW+1)'(DEPTH));
        empty = (count_q == '0);
        push  = in_valid & ~full;
        pop   = out_ready & ~empty;
    end

`ifdef ALU_RES_SAT_EN
    // A set sign bit on overflow means a positive result wrapped negative.
    always_comb begin
        store_z = in_z;
        if (in_of) begin
            store_z = in_z[W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
        end
    end
`else
    always_comb begin
        store_z = in_z;
    end
`endif

    // Storage needs no reset: outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_z[wr_ptr_q]  <= store_z;
            mem_of[wr_ptr_q] <= in_of;
            mem_op[wr_ptr_q] <= in_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            of_sticky_q <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push && in_of) begin
                of_sticky_q <= 1'b1;
            end else if (of_clear) begin
                of_sticky_q <= 1'b0;
            end
            if (push && in_of && (ovf_cnt_q != '1)) begin
                ovf_cnt_q <= ovf_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        in_ready  = ~full;
        out_valid = ~empty;
        out_z     = empty ? '0   : mem_z[rd_ptr_q];
        out_of    = empty ? 1'b0 : mem_of[rd_ptr_q];
        out_op    = empty ? 3'b0 : mem_op[rd_ptr_q];
        count     = count_q;
        of_sticky = of_sticky_q;
        ovf_cnt   = ovf_cnt_q;
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: directed pushes queue expected entries, a monitor checks pops.
module tb_alu_result_fifo;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, in_of, out_valid, out_ready, out_of, of_sticky, of_clear;
    logic [7:0] in_z, out_z, ovf_cnt;
    logic [2:0] in_op, out_op;
    logic [2:0] count;

    typedef struct packed {
        logic [7:0] z;
        logic       of;
        logic [2:0] op;
    } ent_t;

    ent_t exp_q[$];
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    alu_result_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_z      (in_z),
        .in_of     (in_of),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_of    (out_of),
        .out_op    (out_op),
        .count     (count),
        .of_sticky (of_sticky),
        .of_clear  (of_clear),
        .ovf_cnt   (ovf_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Expected stored Z for an accepted entry.
    function automatic logic [7:0] exp_z(input logic [7:0] z, input logic of);
`ifdef ALU_RES_SAT_EN
        if (of) return z[7] ? 8'h7F : 8'h80;
`endif
        return z;
    endfunction

    // Scoreboard producer: record whatever the FIFO accepts this cycle.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) exp_q.push_back('{exp_z(in_z, in_of), in_of, in_op});
    end

    // Monitor: compare the head whenever it is being taken.
    always @(negedge clk) begin
        ent_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {24'h0, out_z}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("out_z", {24'h0, out_z}, {24'h0, e.z});
                chk("out_of", {31'h0, out_of}, {31'h0, e.of});
                chk("out_op", {29'h0, out_op}, {29'h0, e.op});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [7:0] z, input logic of, input logic [2:0] op);
        in_valid = v;
        in_z     = z;
        in_of    = of;
        in_op    = op;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        of_clear = 1'b0;
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        step();
        step();
        rst = 1'b0;
        chk("reset_count", {29'h0, count}, 32'd0);
        chk("reset_out_valid", {31'h0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'h0, in_ready}, 32'd1);
        chk("reset_of_sticky", {31'h0, of_sticky}, 32'd0);
        chk("reset_ovf_cnt", {24'h0, ovf_cnt}, 32'd0);
        chk("reset_out_z", {24'h0, out_z}, 32'd0);

        // 1: one-cycle latency, held while not ready
        set_in(1'b1, 8'h05, 1'b0, 3'd0);
        step();
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        chk("t1_out_valid", {31'h0, out_valid}, 32'd1);
        chk("t1_out_z", {24'h0, out_z}, 32'h05);
        chk("t1_count", {29'h0, count}, 32'd1);
        step();
        step();
        chk("t1_hold_z", {24'h0, out_z}, 32'h05);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_drained", {29'h0, count}, 32'd0);

        // 2: fill, refused push on full even with a pop, ordered drain
        set_in(1'b1, 8'h10, 1'b0, 3'd1); step();
        set_in(1'b1, 8'h20, 1'b0, 3'd2); step();
        set_in(1'b1, 8'h30, 1'b0, 3'd3); step();
        set_in(1'b1, 8'h40, 1'b0, 3'd4); step();
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        chk("t2_full_count", {29'h0, count}, 32'd4);
        chk("t2_full_in_ready", {31'h0, in_ready}, 32'd0);
        set_in(1'b1, 8'h50, 1'b0, 3'd5);
        out_ready = 1'b1;
        step();
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        chk("t2_refused_count", {29'h0, count}, 32'd3);
        step(); step(); step();
        out_ready = 1'b0;
        chk("t2_drained", {29'h0, count}, 32'd0);

        // 3: streaming push+pop across pointer wrap
        set_in(1'b1, 8'd0, 1'b0, 3'd6);
        step();
        out_ready = 1'b1;
        for (int i = 1; i < 10; i++) begin
            set_in(1'b1, 8'(i), 1'b0, 3'd6);
            step();
            chk("t3_stream_count", {29'h0, count}, 32'd1);
        end
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        step();
        out_ready = 1'b0;
        chk("t3_drained", {29'h0, count}, 32'd0);

        // 4: overflow entries, sticky and count
        set_in(1'b1, 8'h80, 1'b1, 3'd0);
        step();
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        chk("t4_of_sticky", {31'h0, of_sticky}, 32'd1);
        chk("t4_ovf_cnt", {24'h0, ovf_cnt}, 32'd1);
`ifdef ALU_RES_SAT_EN
        chk("t4_pos_ovf_z", {24'h0, out_z}, 32'h7F);
`else
        chk("t4_pos_ovf_z", {24'h0, out_z}, 32'h80);
`endif
        chk("t4_pos_ovf_of", {31'h0, out_of}, 32'd1);
        set_in(1'b1, 8'h7F, 1'b1, 3'd1);
        step();
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        chk("t4_ovf_cnt2", {24'h0, ovf_cnt}, 32'd2);
        out_ready = 1'b1;
        step();
`ifdef ALU_RES_SAT_EN
        chk("t4_neg_ovf_z", {24'h0, out_z}, 32'h80);
`else
        chk("t4_neg_ovf_z", {24'h0, out_z}, 32'h7F);
`endif
        step();
        out_ready = 1'b0;

        // 5: clear alone, then set beats clear, then clear again
        of_clear = 1'b1;
        step();
        of_clear = 1'b0;
        chk("t5_cleared", {31'h0, of_sticky}, 32'd0);
        set_in(1'b1, 8'h81, 1'b1, 3'd7);
        of_clear = 1'b1;
        step();
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        chk("t5_set_wins", {31'h0, of_sticky}, 32'd1);
        chk("t5_ovf_cnt", {24'h0, ovf_cnt}, 32'd3);
        step();
        of_clear = 1'b0;
        chk("t5_clear_again", {31'h0, of_sticky}, 32'd0);
        chk("t5_ovf_cnt_kept", {24'h0, ovf_cnt}, 32'd3);
        out_ready = 1'b1;
        step();

        // ovf_cnt saturates at all-ones
        for (int i = 0; i < 260; i++) begin
            set_in(1'b1, 8'(i), 1'b1, 3'(i));
            step();
        end
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        step();
        out_ready = 1'b0;
        chk("sat_ovf_cnt", {24'h0, ovf_cnt}, 32'hFF);

        // 6: reset flushes a partially filled FIFO
        set_in(1'b1, 8'hA1, 1'b0, 3'd1); step();
        set_in(1'b1, 8'hA2, 1'b0, 3'd2); step();
        set_in(1'b1, 8'hA3, 1'b0, 3'd3); step();
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        chk("t6_count3", {29'h0, count}, 32'd3);
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        chk("t6_count", {29'h0, count}, 32'd0);
        chk("t6_out_valid", {31'h0, out_valid}, 32'd0);
        chk("t6_in_ready", {31'h0, in_ready}, 32'd1);
        chk("t6_ovf_cnt", {24'h0, ovf_cnt}, 32'd0);
        chk("t6_out_z", {24'h0, out_z}, 32'd0);
        set_in(1'b1, 8'h5A, 1'b0, 3'd4);
        step();
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        chk("t6_new_head", {24'h0, out_z}, 32'h5A);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t6_drained", {29'h0, count}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
